// File: rtl/poly1305_ds.sv
// poly1305_ds: digit-serial Poly1305 engine, consumes DIGIT bits of clamped r per multiply cycle
module poly1305_ds #(
    parameter int DIGIT = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_ld,
    input  logic [127:0] r,
    input  logic [127:0] s,
    input  logic [127:0] m,
    input  logic [4:0]   nbytes,
    input  logic         ld,
    input  logic         first,
    input  logic         last,
    output logic [127:0] p,
    output logic         rdy,
    output logic         tag_vld
);
    localparam int N  = 128 / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = DIGIT + 132;
    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [129:0] P130  = {2'b11, {31{4'hf}}, 4'hb};

    typedef enum logic [1:0] {IDLE, MUL, RED, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [130:0]       a_q, a_d, acc_q, acc_d;
    logic [129:0]       h_q, h_d;
    logic [127:0]       rc_q, rc_d, s_q, s_d, p_q, p_d;
    logic               last_q, last_d, tag_q, tag_d;

    logic               full, ge;
    logic [128:0]       one_n, mp;
    logic [DIGIT-1:0]   dig;
    logic [PW-1:0]      sum;
    logic [130+DIGIT:0] sh;
    logic [130:0]       acc_n, a_n, x1;
    logic [129:0]       x2;

    // Padding, multiply-accumulate of one r digit, and folding of bits >= 2^130 back in as *5.
    // The multiplicand a is advanced by 2^DIGIT each cycle so r digits are taken LSB first.
    always_comb begin
        full  = nbytes[4] | ~|nbytes;
        one_n = 129'd1 << {nbytes[3:0], 3'b000};
        mp    = full ? {1'b1, m} : (({1'b0, m} & (one_n - 129'd1)) | one_n);
        dig   = rc_q[int'(cnt_q) * DIGIT +: DIGIT];
        sum   = PW'(acc_q) + PW'(a_q) * PW'(dig);
        acc_n = 131'(sum[129:0]) + 131'(sum[PW-1:130]) * 131'd5;
        sh    = {a_q, {DIGIT{1'b0}}};
        a_n   = 131'(sh[129:0]) + 131'(sh[130+DIGIT:130]) * 131'd5;
        x1    = 131'(acc_q[129:0]) + (acc_q[130] ? 131'd5 : 131'd0);
        x2    = x1[129:0] + (x1[130] ? 130'd5 : 130'd0);
        ge    = h_q >= P130;
    end

    // FSM next state and register updates; key_ld overrides any block in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        h_d     = h_q;
        rc_d    = rc_q;
        s_d     = s_q;
        p_d     = p_q;
        last_d  = last_q;
        tag_d   = 1'b0;
        if (key_ld) begin
            state_d = IDLE;
            rc_d    = r & CLAMP;
            s_d     = s;
            h_d     = '0;
        end else begin
            case (state_q)
                IDLE: if (ld) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    a_d     = 131'(first ? 130'd0 : h_q) + 131'(mp);
                    last_d  = last;
                end
                MUL: begin
                    acc_d   = acc_n;
                    a_d     = a_n;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(N - 1)) ? RED : MUL;
                end
                RED: begin
                    h_d     = x2;
                    state_d = last_q ? FIN : IDLE;
                end
                FIN: begin
                    p_d     = h_q[127:0] + (ge ? 128'd5 : 128'd0) + s_q;
                    tag_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            h_q     <= '0;
            rc_q    <= '0;
            s_q     <= '0;
            p_q     <= '0;
            last_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            h_q     <= h_d;
            rc_q    <= rc_d;
            s_q     <= s_d;
            p_q     <= p_d;
            last_q  <= last_d;
            tag_q   <= tag_d;
        end
    end

    assign p       = p_q;
    assign rdy     = state_q == IDLE;
    assign tag_vld = tag_q;
endmodule

// File: tb/tb_poly1305_ds.sv
// tb_poly1305_ds: scoreboard bench for poly1305_ds across DIGIT = 8, 16, 32, 64
module tb_poly1305_ds;
    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam logic [127:0] R0    = 128'h0806d5400e52447c036d555408bed685;
    localparam logic [127:0] S0    = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] B1    = 128'h6f4620636968706172676f7470797243;
    localparam logic [127:0] B2    = 128'h6f7247206863726165736552206d7572;
    localparam logic [127:0] B3    = 128'h7075;
    localparam logic [127:0] B3X   = 128'hffffffffffffffffffffffffffff7075;
    localparam logic [127:0] TAG0  = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [259:0] PM    = (260'd1 << 130) - 260'd5;

    logic         clk = 1'b0;
    logic         reset_n, key_ld, ld, first, last;
    logic [127:0] r, s, m;
    logic [4:0]   nbytes;
    logic [127:0] p_w [4];
    logic         rdy_w [4];
    logic         tag_w [4];
    logic         rdy_all;

    int           n_chk = 0;
    int           n_bad = 0;
    int           obs_rd = 0;
    logic [127:0] exp_q [$];
    logic [127:0] obs_q [$];
    logic [129:0] mh;
    logic [127:0] mrc, ms;

    always #5 clk = ~clk;
    assign rdy_all = rdy_w[0] & rdy_w[1] & rdy_w[2] & rdy_w[3];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        poly1305_ds #(.DIGIT(8 << g)) u_dut (
            .clk(clk), .reset_n(reset_n), .key_ld(key_ld), .r(r), .s(s), .m(m),
            .nbytes(nbytes), .ld(ld), .first(first), .last(last),
            .p(p_w[g]), .rdy(rdy_w[g]), .tag_vld(tag_w[g])
        );
    end

    always @(negedge clk) if (tag_w[2]) obs_q.push_back(p_w[2]);

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tg, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tg, got, exp);
        end
    endtask

    function automatic logic [129:0] blk(input logic [129:0] h, input logic [127:0] rc,
                                         input logic [127:0] mm, input int nb, input bit f);
        logic [259:0] a;
        logic [128:0] mp = '0;
        int n = (nb == 0 || nb >= 16) ? 16 : nb;
        for (int i = 0; i < n; i++) mp[8*i +: 8] = mm[8*i +: 8];
        mp[8*n] = 1'b1;
        a = 260'(f ? 130'd0 : h) + 260'(mp);
        a = (a * 260'(rc)) % PM;
        return a[129:0];
    endfunction

    task automatic wait_rdy(input bit all);
        int k = 0;
        while (!(all ? rdy_all : rdy_w[2]) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk("rdy_timeout", 128'(all ? rdy_all : rdy_w[2]), 128'd1);
    endtask

    task automatic key(input logic [127:0] rr, input logic [127:0] ss);
        r = rr;
        s = ss;
        key_ld = 1'b1;
        @(posedge clk); #1;
        key_ld = 1'b0;
        mrc = rr & CLAMP;
        ms = ss;
        mh = '0;
    endtask

    task automatic send(input logic [127:0] mm, input int nb, input bit f, input bit l, input bit all);
        wait_rdy(all);
        m = mm;
        nbytes = 5'(nb);
        first = f;
        last = l;
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        first = 1'b0;
        last = 1'b0;
        mh = blk(mh, mrc, mm, nb, f);
        if (l) exp_q.push_back(mh[127:0] + ms);
    endtask

    task automatic lat_chk(input string tg, input int ex);
        int c = 1;
        while (!rdy_w[2] && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tg, 128'(c), 128'(ex));
    endtask

    task automatic drain();
        logic [127:0] o, e;
        @(negedge clk); #1;
        while (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = ~o;
            chk("tag", o, e);
        end
    endtask

    task automatic rfc(input logic [127:0] lm, input string tg);
        send(B1, 16, 1'b1, 1'b0, 1'b0);
        send(B2, 16, 1'b0, 1'b0, 1'b0);
        send(lm, 2, 1'b0, 1'b1, 1'b0);
        lat_chk({tg, "_lat"}, 7);
        drain();
        chk({tg, "_p"}, p_w[2], TAG0);
    endtask

    task automatic sweep();
        int lat [4] = '{0, 0, 0, 0};
        logic tv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        wait_rdy(1'b1);
        key(R0, S0);
        send(B1, 16, 1'b1, 1'b0, 1'b1);
        send(B2, 16, 1'b0, 1'b0, 1'b1);
        send(B3, 2, 1'b0, 1'b1, 1'b1);
        for (int c = 2; c <= 24; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (lat[k] == 0 && rdy_w[k]) begin
                    lat[k] = c;
                    tv[k] = tag_w[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_lat_d%0d", 8 << k), 128'(lat[k]), 128'(128 / (8 << k) + 3));
            chk($sformatf("sweep_tagvld_d%0d", 8 << k), 128'(tv[k]), 128'd1);
            chk($sformatf("sweep_p_d%0d", 8 << k), p_w[k], TAG0);
        end
        drain();
    endtask

    initial begin
        int nt;
        int nbl [5] = '{1, 15, 0, 16, 7};
        reset_n = 1'b0; key_ld = 1'b0; ld = 1'b0; first = 1'b0; last = 1'b0;
        r = '0; s = '0; m = '0; nbytes = '0; mh = '0; mrc = '0; ms = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p", p_w[2], '0);
        chk("rst_rdy", 128'(rdy_w[2]), 128'd1);
        chk("rst_tagvld", 128'(tag_w[2]), 128'd0);
        reset_n = 1'b1;

        key(R0, S0);
        nt = obs_q.size();
        send(B1, 16, 1'b1, 1'b0, 1'b0);
        lat_chk("lat_blk", 6);
        chk("p_hold0", p_w[2], '0);
        send(B2, 16, 1'b0, 1'b0, 1'b0);
        send(B3, 2, 1'b0, 1'b1, 1'b0);
        lat_chk("lat_last", 7);
        drain();
        chk("rfc_p", p_w[2], TAG0);
        chk("tag_once", 128'(obs_q.size() - nt), 128'd1);

        key(R0 | ~CLAMP, S0);
        rfc(B3X, "clamp");

        for (int i = 0; i < 3; i++) begin
            send(B1, 16, 1'b1, 1'b0, 1'b0);
            lat_chk("rep_lat_blk", 6);
            chk("rep_p_hold", p_w[2], TAG0);
            send(B2, 16, 1'b0, 1'b0, 1'b0);
            send(B3, 2, 1'b0, 1'b1, 1'b0);
            lat_chk("rep_lat", 7);
            drain();
            chk("rep_p", p_w[2], TAG0);
        end

        send(B1, 16, 1'b1, 1'b0, 1'b0);
        m = ~B1; nbytes = 5'd5; first = 1'b1; last = 1'b1; ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0; first = 1'b0; last = 1'b0;
        send(B2, 16, 1'b0, 1'b0, 1'b0);
        send(B3, 2, 1'b0, 1'b1, 1'b0);
        lat_chk("busy_lat", 7);
        drain();
        chk("busy_p", p_w[2], TAG0);

        send(B1, 16, 1'b1, 1'b0, 1'b0);
        send(B2, 16, 1'b0, 1'b0, 1'b0);
        key(R0, S0);
        chk("abort_rdy", 128'(rdy_w[2]), 128'd1);
        chk("abort_tagvld", 128'(tag_w[2]), 128'd0);
        rfc(B3, "abort");

        for (int t = 0; t < 5; t++) begin
            int nblk = $urandom_range(1, 3);
            key({$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom(), $urandom(), $urandom()});
            for (int b = 0; b < nblk; b++)
                send({$urandom(), $urandom(), $urandom(), $urandom()},
                     (b == nblk - 1) ? nbl[t] : $urandom_range(0, 16), b == 0, b == nblk - 1, 1'b0);
            lat_chk("rand_lat", 7);
            drain();
        end

        sweep();

        key(R0, S0);
        send(B1, 16, 1'b1, 1'b0, 1'b0);
        send(B2, 16, 1'b0, 1'b0, 1'b0);
        send(B3, 2, 1'b0, 1'b1, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("fin_rdy", 128'(rdy_w[2]), 128'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("finrst_p", p_w[2], '0);
        chk("finrst_rdy", 128'(rdy_w[2]), 128'd1);
        chk("finrst_tagvld", 128'(tag_w[2]), 128'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        key(R0, S0);
        send(B1, 16, 1'b1, 1'b1, 1'b0);
        lat_chk("one_lat", 7);
        drain();

        repeat (3) @(posedge clk);
        drain();
        chk("tag_missing", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
